logic_unit_arbiter: RTL and testbench
=====================================

// Module: logic_unit_arbiter
// PURPOSE
// - Shares one WIDTH-bit bitwise logic datapath (OR/AND/XOR/NOR) between NREQ requesters.
// - Arbitration is round-robin. The result is registered once, and every port uses a valid/ready handshake.
// - Sits between the issue/execute stage clients (e.g. ALU, CSR unit) and the shared logic datapath.
// PARAMETERS
// - NREQ   2   number of requesters, legal range 2..4
// - WIDTH  32  operand/result width in bits
// PORTS
// - clk        in   1           rising-edge clock
// - rst        in   1           synchronous reset, active-high
// - req_valid  in   NREQ        bit i: requester i presents an operation
// - req_ready  out  NREQ        bit i: requester i's operation accepted this cycle
// - req_op     in   2*NREQ      op for requester i at [2i+1:2i]; 00 OR, 01 AND, 10 XOR, 11 NOR
// - req_a      in   WIDTH*NREQ  operand A for requester i at [WIDTH*i +: WIDTH]
// - req_b      in   WIDTH*NREQ  operand B for requester i at [WIDTH*i +: WIDTH]
// - rsp_valid  out  1           result register holds a valid result
// - rsp_ready  in   1           consumer accepts the result this cycle
// - rsp_data   out  WIDTH       result word
// - rsp_id     out  2           index of the requester that owns rsp_data
// BEHAVIOUR
// - Reset (sync, rst=1 at posedge):
//   - rsp_valid=0, rsp_data=0, rsp_id=0, state=EMPTY.
//   - last_grant=NREQ-1, so requester 0 has first priority.
//   - req_ready is 0 while rst=1.
// - State machine:
//   - EMPTY: no result held.
//   - FULL: result held, rsp_valid=1.
// - can_accept = (state==EMPTY) | rsp_ready. This is combinational, giving a pass-through drain.
// - Grant selection:
//   - Search req_valid starting at (last_grant+1) mod NREQ, wrapping; the first set bit wins.
//   - Exactly one req_ready bit is high, and only if can_accept and some req_valid is set.
//   - req_ready is combinational from req_valid/state/rsp_ready; there is no registered grant.
// - Transfer: requester i is accepted when req_valid[i] & req_ready[i] at a posedge. On that edge:
//   - rsp_data <= f(op_i, a_i, b_i), rsp_id <= i, rsp_valid <= 1.
//   - last_grant <= i; state -> FULL.
// - Latency is exactly 1 cycle from acceptance to rsp_valid. Throughput is 1 result/cycle when rsp_ready=1.
// - Drain: rsp_valid & rsp_ready with no new acceptance -> state EMPTY, rsp_valid <= 0.
//   - rsp_data/rsp_id keep their last value.
// - Simultaneous drain and accept: state stays FULL and the new result replaces the old one on the same edge.
// - Backpressure: FULL & !rsp_ready -> all req_ready=0; rsp_data/rsp_id/rsp_valid held stable.
// - last_grant updates only on an accepted transfer. Idle cycles and stalls do not rotate priority.
// - Requester rules:
//   - Once req_valid[i] is raised, the requester holds it and req_op/req_a/req_b stable until accepted.
//   - The block does not check this rule.
//   - Non-requesting lanes are don't-care.
// - Arithmetic: pure bitwise on WIDTH bits; NOR = ~(a|b). No flags and no carries.
// - rsp_id is zero-extended to 2 bits when NREQ<4.
// - Reset mid-operation: a held result is discarded and never presented. Requesters must re-present after reset.
// TESTING
// 1. Reset:
//    - Stimulus: rst=1 for 2 cycles with all req_valid=1.
//    - Required: req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0; the first grant after release goes to requester 0.
// 2. Single OR:
//    - Stimulus: req0 op=00, a=0xF0F0_0000, b=0x0000_0F0F, rsp_ready=1.
//    - Required: req_ready[0]=1 the same cycle; next cycle rsp_valid=1, rsp_data=0xF0F0_0F0F, rsp_id=0.
// 3. Op coverage (a=0xFFFF_0000, b=0x0F0F_0F0F):
//    - Required: AND -> 0x0F0F_0000, XOR -> 0xF0F0_0F0F, NOR -> 0x0000_F0F0.
// 4. Fairness (NREQ=2):
//    - Stimulus: req_valid=2'b11 held for 6 cycles, rsp_ready=1.
//    - Required: grants 0,1,0,1,0,1; rsp_valid=1 on every cycle after the first.
// 5. Backpressure:
//    - Stimulus: result pending, rsp_ready=0 for 3 cycles.
//    - Required: req_ready=0 and rsp_data/rsp_id stable throughout.
//    - Then rsp_ready=1: the old result is consumed and the waiting request is accepted on the same edge.
// 6. Reset mid-op:
//    - Stimulus: rst=1 while rsp_valid=1.
//    - Required: next cycle rsp_valid=0, rsp_data=0; the stale result never appears with rsp_valid=1.

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one registered bitwise logic datapath (OR/AND/XOR/NOR)
// between NREQ valid/ready requesters, with a single-entry result register.
module logic_unit_arbiter #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [2*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [1:0]            rsp_id
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        OP_OR  = 2'b00,
        OP_AND = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    state_e           state_q, state_d;
    logic [1:0]       last_grant_q, last_grant_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [1:0]       id_q, id_d;

    logic [3:0]       valid_pad;
    logic [2:0]       pick;
    logic             grant_found;
    logic [1:0]       grant_idx;
    logic             can_accept;
    logic             accept;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;

    // Returns {found, index}: first requester at or after last+1, wrapping modulo NREQ.
    function automatic logic [2:0] rr_pick(input logic [3:0] v, input logic [1:0] last);
        logic [1:0] idx;
        rr_pick = 3'b000;
        for (int k = 1; k <= NREQ; k++) begin
            idx = 2'((int'(last) + k) % NREQ);
            if (!rr_pick[2] && v[idx]) begin
                rr_pick = {1'b1, idx};
            end
        end
    endfunction

    function automatic logic [WIDTH-1:0] logic_op(input logic [1:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        case (op_e'(op))
            OP_OR:   logic_op = a | b;
            OP_AND:  logic_op = a & b;
            OP_XOR:  logic_op = a ^ b;
            default: logic_op = ~(a | b);
        endcase
    endfunction

    assign valid_pad   = 4'(req_valid);
    assign pick        = rr_pick(valid_pad, last_grant_q);
    assign grant_found = pick[2];
    assign grant_idx   = pick[1:0];

    // Draining the held result frees the register on the same edge, so a new grant can land.
    assign can_accept = (state_q == EMPTY) | rsp_ready;
    assign accept     = can_accept & grant_found & ~rst;
    assign req_ready  = accept ? (NREQ'(1) << grant_idx) : '0;

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == 2'(i)) begin
                sel_op = req_op[2*i +: 2];
                sel_a  = req_a[WIDTH*i +: WIDTH];
                sel_b  = req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    // NOTE: every signal gets a default first so no path through this block infers a latch.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        data_d       = data_q;
        id_d         = id_q;
        if (accept) begin
            state_d      = FULL;
            last_grant_d = grant_idx;
            data_d       = logic_op(sel_op, sel_a, sel_b);
            id_d         = grant_idx;
        end else if (state_q == FULL && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            last_grant_q <= 2'(NREQ - 1);
            data_q       <= '0;
            id_q         <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            data_q       <= data_d;
            id_q         <= id_d;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_data  = data_q;
    assign rsp_id    = id_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter: directed scenarios plus random traffic, a transaction-level
// reference model feeding a scoreboard queue, and a monitor that pops on each result handshake.
module tb_logic_unit_arbiter;

    localparam int N = 2;
    localparam int W = 32;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [2*N-1:0] req_op;
    logic [W*N-1:0] req_a;
    logic [W*N-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_data;
    logic [1:0]     rsp_id;

    logic_unit_arbiter #(.NREQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic [1:0]   id;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    // Requester-side lane state: a pending lane holds its op/operands until accepted.
    bit         pend[N];
    logic [1:0] lop[N];
    logic [W-1:0] la[N];
    logic [W-1:0] lb[N];

    // Reference model: result register occupancy and the owner of the most recent grant.
    bit  m_full;
    int  m_last;

    bit  rst_v;
    bit  rdy;
    bit  keep_busy;
    int  last_acc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            2'b00:   return a | b;
            2'b01:   return a & b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic set_lane(input int i, input logic [1:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b);
        pend[i] = 1'b1;
        lop[i]  = op;
        la[i]   = a;
        lb[i]   = b;
    endtask

    task automatic rand_lane(input int i);
        set_lane(i, 2'($urandom_range(3)), $urandom, $urandom);
    endtask

    // One clock cycle: drive at the falling edge, check combinational outputs, advance the model
    // at the rising edge, and return at the next falling edge.
    task automatic step();
        logic [N-1:0] exp_rdy;
        int g;
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = pend[i];
            req_op[2*i +: 2]    = pend[i] ? lop[i] : 2'($urandom_range(3));
            req_a[W*i +: W]     = pend[i] ? la[i] : $urandom;
            req_b[W*i +: W]     = pend[i] ? lb[i] : $urandom;
        end
        rsp_ready = rdy;
        rst       = rst_v;
        #1;
        g       = -1;
        exp_rdy = '0;
        if (!rst_v && (!m_full || rdy)) begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (m_last + k) % N;
                if (g < 0 && pend[idx]) g = idx;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        check("rsp_valid", 64'(rsp_valid), 64'(m_full));
        @(posedge clk);
        if (rst_v) begin
            m_full = 1'b0;
            m_last = N - 1;
            sb.delete();
        end else if (g >= 0) begin
            exp_t e;
            e.data = ref_op(lop[g], la[g], lb[g]);
            e.id   = 2'(g);
            sb.push_back(e);
            m_full  = 1'b1;
            m_last  = g;
            pend[g] = 1'b0;
            if (keep_busy) rand_lane(g);
        end else if (m_full && rdy) begin
            m_full = 1'b0;
        end
        last_acc = g;
        @(negedge clk);
    endtask

    function automatic bit busy();
        bit b;
        b = m_full;
        for (int i = 0; i < N; i++) b |= pend[i];
        return b;
    endfunction

    task automatic drain();
        rdy = 1'b1;
        for (int t = 0; t < 20 && busy(); t++) step();
        check("drain_done", 64'(busy()), 64'(0));
    endtask

    // Monitor: every completed result handshake must match the oldest expected entry.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rsp_unexpected: got data %0h id %0d, expected no result", rsp_data, rsp_id);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_data", 64'(rsp_data), 64'(e.data));
                    check("rsp_id", 64'(rsp_id), 64'(e.id));
                end
            end
        end
    end

    initial begin
        logic [W-1:0] held_data;
        logic [1:0]   held_id;
        int           exp_seq[6];
        logic [1:0]   ops[3];
        logic [W-1:0] op_res[3];

        exp_seq   = '{0, 1, 0, 1, 0, 1};
        ops       = '{2'b01, 2'b10, 2'b11};
        op_res    = '{32'h0F0F_0000, 32'hF0F0_0F0F, 32'h0000_F0F0};
        m_full    = 1'b0;
        m_last    = N - 1;
        keep_busy = 1'b0;
        last_acc  = -1;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        rst       = 1'b1;
        rst_v     = 1'b1;
        rdy       = 1'b0;
        @(negedge clk);

        // Reset held with every requester asking.
        for (int i = 0; i < N; i++) rand_lane(i);
        step();
        step();
        check("reset_rsp_data", 64'(rsp_data), 64'(0));
        check("reset_rsp_id", 64'(rsp_id), 64'(0));
        rst_v = 1'b0;
        rdy   = 1'b1;
        step();
        check("first_grant", 64'(last_acc), 64'(0));
        drain();

        // Single OR.
        set_lane(0, 2'b00, 32'hF0F0_0000, 32'h0000_0F0F);
        step();
        check("or_grant", 64'(last_acc), 64'(0));
        check("or_valid", 64'(rsp_valid), 64'(1));
        check("or_data", 64'(rsp_data), 64'(32'hF0F0_0F0F));
        check("or_id", 64'(rsp_id), 64'(0));

        // Remaining ops, back to back.
        for (int k = 0; k < 3; k++) begin
            set_lane(0, ops[k], 32'hFFFF_0000, 32'h0F0F_0F0F);
            step();
            check("op_data", 64'(rsp_data), 64'(op_res[k]));
        end
        drain();

        // Fairness from reset with both requesters continuously busy.
        rst_v = 1'b1;
        step();
        rst_v     = 1'b0;
        keep_busy = 1'b1;
        for (int i = 0; i < N; i++) rand_lane(i);
        for (int k = 0; k < 6; k++) begin
            step();
            check("fair_grant", 64'(last_acc), 64'(exp_seq[k]));
            check("fair_valid", 64'(rsp_valid), 64'(1));
        end
        keep_busy = 1'b0;
        drain();

        // Backpressure: result held, requester 1 waits, then drain and accept on one edge.
        rand_lane(0);
        step();
        rand_lane(1);
        rdy       = 1'b0;
        held_data = rsp_data;
        held_id   = rsp_id;
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_data_stable", 64'(rsp_data), 64'(held_data));
            check("bp_id_stable", 64'(rsp_id), 64'(held_id));
        end
        rdy = 1'b1;
        step();
        check("bp_release_grant", 64'(last_acc), 64'(1));
        drain();

        // Reset while a result is held.
        rdy = 1'b0;
        set_lane(0, 2'b10, 32'hDEAD_BEEF, 32'h1234_5678);
        step();
        check("midrst_pre_valid", 64'(rsp_valid), 64'(1));
        rst_v = 1'b1;
        step();
        rst_v = 1'b0;
        check("midrst_valid", 64'(rsp_valid), 64'(0));
        check("midrst_data", 64'(rsp_data), 64'(0));
        rdy = 1'b1;
        for (int k = 0; k < 3; k++) step();

        // Random traffic with random backpressure.
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(1) == 1) rand_lane(i);
            end
            rdy = ($urandom_range(3) != 0);
            step();
        end
        drain();
        check("scoreboard_empty", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
